// File: rtl/pixel_source.sv
// Transmit side of the pixel request interface: a byte FIFO feeds one pixel_in/pix_req
// strobe per pixel, and a loopback checker counts returns that differ from byte ^ KEY.
module pixel_source #(
   parameter int         DEPTH = 8,
   parameter logic [7:0] KEY   = 8'b11001100
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       start,
   input  logic [7:0] frame_len,
   output logic       pix_req,
   output logic [7:0] pixel_in,
   input  logic [7:0] pixel_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] sent_cnt,
   output logic [7:0] err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DRAIN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] level;
   logic          push;
   logic          pop;
   logic          fifo_empty;

   logic          frame_go;
   logic          zero_go;
   logic          drain_last;
   logic [7:0]    len_q;
   logic [7:0]    pop_cnt;

   logic          req_d;
   logic [7:0]    pix_d;
   logic          mismatch;

   assign s_ready    = (level != FULL_LEVEL);
   assign fifo_empty = (level == '0);
   assign push       = s_valid && s_ready;
   assign busy       = (state != IDLE);
   assign mismatch   = req_d && (pixel_out != (pix_d ^ KEY));

   // Storage is not reset; emptiness is tracked entirely by the level counter.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // SEND is held through the cycle that shows the last pix_req, so DRAIN covers
   // that pixel's return and the following err_cnt update.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      frame_go   = 1'b0;
      zero_go    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (frame_len != 8'd0) begin
                  frame_go   = 1'b1;
                  state_next = SEND;
               end else begin
                  zero_go = 1'b1;
               end
            end
         end
         SEND: begin
            pop = !fifo_empty && (pop_cnt != len_q);
            if (sent_cnt == len_q) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         drain_last <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         drain_last <= (state == DRAIN) && !drain_last;
         done       <= (state_next == DONE) || zero_go;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         len_q   <= 8'd0;
         pop_cnt <= 8'd0;
      end else if (frame_go) begin
         len_q   <= frame_len;
         pop_cnt <= 8'd0;
      end else if (pop) begin
         pop_cnt <= pop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pix_req  <= 1'b0;
         pixel_in <= 8'd0;
      end else begin
         pix_req <= pop;
         if (pop) begin
            pixel_in <= mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sent_cnt <= 8'd0;
      end else if (frame_go || zero_go) begin
         sent_cnt <= 8'd0;
      end else if (pop) begin
         sent_cnt <= sent_cnt + 8'd1;
      end
   end

   // The consumer answers one cycle after pix_req, so the sent byte is delayed to line up.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_d <= 1'b0;
         pix_d <= 8'd0;
      end else begin
         req_d <= pix_req;
         pix_d <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_cnt <= 8'd0;
      end else if (frame_go || zero_go) begin
         err_cnt <= 8'd0;
      end else if (mismatch && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
